multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback, and drives every datapath mux and enable. It generates the 4-bit ALU control code and consumes the ALU's 4-bit flag vector to resolve conditional branches. It stalls on a single-bit memory ready handshake.

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 166 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode, ALU, immediate and mux encodings for multicycle_controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_LUI, S_AUIPC
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_RDATA   = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALUOUT  = 1'b1;

  localparam logic [1:0] FLAG_Z = 2'd0;
  localparam logic [1:0] FLAG_N = 2'd1;
  localparam logic [1:0] FLAG_C = 2'd2;
  localparam logic [1:0] FLAG_V = 2'd3;

  // Branch condition from funct3 and the flags of rs1 - rs2; reserved encodings never branch
  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
    logic lt;
    lt = fl[FLAG_N] ^ fl[FLAG_V];
    case (f3)
      3'b000:  branch_taken = fl[FLAG_Z];
      3'b001:  branch_taken = ~fl[FLAG_Z];
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      3'b110:  branch_taken = ~fl[FLAG_C];
      3'b111:  branch_taken = fl[FLAG_C];
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU operation class and funct fields to the 4-bit ALU control code
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  // Funct decode; only register-register 000 with bit 30 set selects subtract
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM; lui/auipc support under CTRL_UTYPE_EN
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic       mem_ok;
  logic [1:0] alu_op;
  logic       pc_write_d, mem_write_d, ir_write_d, reg_write_d, illegal_d;

  assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State register; reset parks the machine in FETCH without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state: memory states hold for mem_ok, DECODE dispatches on the opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
`ifdef CTRL_UTYPE_EN
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALRPC, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRPC;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; strobes are raw here and gated by reset below
  always_comb begin
    adr_src     = ADR_PC;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_op      = ALUOP_ADD;
    pc_write_d  = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
        ir_write_d = mem_ok;
        pc_write_d = mem_ok;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR: illegal_d = 1'b0;
`ifdef CTRL_UTYPE_EN
          OP_LUI, OP_AUIPC: illegal_d = 1'b0;
`endif
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEMADR, S_EXECI, S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        if (state_q == S_EXECI) alu_op = ALUOP_FUNCT;
      end
      S_MEMREAD:  adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        result_src  = RES_RDATA;
        reg_write_d = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = ADR_ALUOUT;
        mem_write_d = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write_d = 1'b1;
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_op     = ALUOP_SUB;
        pc_write_d = branch_taken(funct3, flags);
        illegal_d  = (funct3[2:1] == 2'b01);
      end
      S_JAL, S_JALRPC: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write_d = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      default: illegal_d = 1'b0;
    endcase
  end

  // Immediate format follows the opcode so address and execute steps see the right layout
  always_comb begin
    case (op)
      OP_STORE:        imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:         imm_src = IMM_I;
    endcase
  end

  assign pc_write      = pc_write_d  & ~reset;
  assign mem_write     = mem_write_d & ~reset;
  assign ir_write      = ir_write_d  & ~reset;
  assign reg_write     = reg_write_d & ~reset;
  assign illegal_instr = illegal_d   & ~reset;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_B = 7'b1100011, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;
  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] flags;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic [18:0] obs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .flags(flags), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
  );

  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};

  task automatic check(input string nm, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = T_R;
    #2;
    check("reset_strobes", {pc_write, ir_write, mem_write, reg_write, illegal_instr}, 0);
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model: instruction -> expected cycle trace ----------------
  typedef struct { logic mr; logic ck_imm; logic [18:0] v; } step_t;
  step_t exp_q[$];

  function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic rw, input logic [1:0] rs, input logic [1:0] a,
      input logic [1:0] b, input logic [2:0] imm, input logic [3:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [3:0] fdec(input logic [2:0] f3, input logic f7, input logic rtype);
    case (f3)
      3'b000: return (rtype && f7) ? 4'b0001 : 4'b0000;
      3'b001: return 4'b0110;
      3'b010: return 4'b0101;
      3'b011: return 4'b1001;
      3'b100: return 4'b0100;
      3'b101: return f7 ? 4'b1000 : 4'b0111;
      3'b110: return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic [3:0] fl);
    logic z, n, c, v;
    {v, c, n, z} = fl;
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100: return n != v;
      3'b101: return n == v;
      3'b110: return !c;
      3'b111: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == T_SW) return 3'b001;
    if (o == T_B) return 3'b010;
    if (o == T_JAL) return 3'b011;
    if (o == T_LUI || o == T_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic legal(input logic [6:0] o);
`ifdef CTRL_UTYPE_EN
    if (o == T_LUI || o == T_AUIPC) return 1'b1;
`endif
    return o inside {T_LW, T_SW, T_R, T_I, T_B, T_JAL, T_JALR};
  endfunction

  task automatic push(input logic mr, input logic ck, input logic [18:0] v);
    step_t s;
    s.mr = mr; s.ck_imm = ck; s.v = v;
    exp_q.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [3:0] fl, input int fs, input int ms);
    logic [18:0] wb;
    wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD, 0);
    exp_q.delete();
    for (int k = 0; k < fs; k++) push(0, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0));
    push(1, 0, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0));
    push(rbit(), legal(o), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm_of(o), A_ADD, !legal(o)));
    if (o == T_LW || o == T_SW) begin
      push(rbit(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD, 0));
      for (int k = 0; k <= ms; k++)
        push(k == ms, 0, mk(0, 1, o == T_SW, 0, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD, 0));
      if (o == T_LW) push(rbit(), 0, mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, A_ADD, 0));
    end else if (o == T_R || o == T_I) begin
      push(rbit(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == T_I) ? 2'b01 : 2'b00, 0,
                         fdec(f3, f7, o == T_R), 0));
      push(rbit(), 0, wb);
    end else if (o == T_B) begin
      push(rbit(), 0, mk(taken(f3, fl), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, A_SUB,
                         f3 == 3'b010 || f3 == 3'b011));
    end else if (o == T_JAL) begin
      push(rbit(), 0, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, A_ADD, 0));
      push(rbit(), 0, wb);
    end else if (o == T_JALR) begin
      push(rbit(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD, 0));
      push(rbit(), 0, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, A_ADD, 0));
      push(rbit(), 0, wb);
    end else if (legal(o)) begin
      push(rbit(), 1, mk(0, 0, 0, 0, 0, 2'b00, (o == T_LUI) ? 2'b11 : 2'b01, 2'b01, 3'b100, A_ADD, 0));
      push(rbit(), 0, wb);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic [3:0] fl; logic [15:0] mr_mask;
    int cyc; int chk; logic [3:0] alu; logic pcw; int ill; logic rw; logic [1:0] rs;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int cycles, irw, ill;
    bit left;
    logic [3:0] o_alu;
    logic o_pcw, o_rw;
    logic [1:0] o_rs;
    logic [6:0] pool[9];
    logic [18:0] msk;

    tbl[0]  = '{T_R,    3'b000, 1'b0, 4'b0000, 16'hFFFF, 4,  2, 4'b0000, 1'b0, 0, 1'b1, 2'b00};
    tbl[1]  = '{T_R,    3'b000, 1'b1, 4'b0000, 16'hFFFF, 4,  2, 4'b0001, 1'b0, 0, 1'b1, 2'b00};
    tbl[2]  = '{T_R,    3'b101, 1'b1, 4'b0000, 16'hFFFF, 4,  2, 4'b1000, 1'b0, 0, 1'b1, 2'b00};
    tbl[3]  = '{T_R,    3'b011, 1'b0, 4'b0000, 16'hFFFF, 4,  2, 4'b1001, 1'b0, 0, 1'b1, 2'b00};
    tbl[4]  = '{T_B,    3'b100, 1'b0, 4'b1010, 16'hFFFF, 3,  2, 4'b0001, 1'b0, 0, 1'b0, 2'b00};
    tbl[5]  = '{T_B,    3'b100, 1'b0, 4'b0010, 16'hFFFF, 3,  2, 4'b0001, 1'b1, 0, 1'b0, 2'b00};
    tbl[6]  = '{T_B,    3'b111, 1'b0, 4'b0100, 16'hFFFF, 3,  2, 4'b0001, 1'b1, 0, 1'b0, 2'b00};
    tbl[7]  = '{T_LW,   3'b010, 1'b0, 4'b0000, 16'hFF04, 10, 4, 4'b0000, 1'b0, 0, 1'b1, 2'b01};
    tbl[8]  = '{T_SW,   3'b010, 1'b0, 4'b0000, 16'hFFFF, 4,  3, 4'b0000, 1'b0, 0, 1'b0, 2'b00};
    tbl[9]  = '{T_JAL,  3'b000, 1'b0, 4'b0000, 16'hFFFF, 4,  2, 4'b0000, 1'b1, 0, 1'b1, 2'b00};
    tbl[10] = '{T_JALR, 3'b000, 1'b0, 4'b0000, 16'hFFFF, 5,  3, 4'b0000, 1'b1, 0, 1'b1, 2'b00};
    tbl[11] = '{T_I,    3'b000, 1'b1, 4'b0000, 16'hFFFF, 4,  2, 4'b0000, 1'b0, 0, 1'b1, 2'b00};
    tbl[12] = '{T_I,    3'b101, 1'b1, 4'b0000, 16'hFFFF, 4,  2, 4'b1000, 1'b0, 0, 1'b1, 2'b00};
`ifdef CTRL_UTYPE_EN
    tbl[13] = '{T_LUI,  3'b000, 1'b0, 4'b0000, 16'hFFFF, 4,  2, 4'b0000, 1'b0, 0, 1'b1, 2'b00};
`else
    tbl[13] = '{T_LUI,  3'b000, 1'b0, 4'b0000, 16'hFFFF, 2,  1, 4'b0000, 1'b0, 1, 1'b0, 2'b00};
`endif
    tbl[14] = '{T_B,    3'b010, 1'b0, 4'b1111, 16'hFFFF, 3,  2, 4'b0001, 1'b0, 1, 1'b0, 2'b00};
    tbl[15] = '{7'b0000000, 3'b000, 1'b0, 4'b0000, 16'hFFFF, 2, 1, 4'b0000, 1'b0, 1, 1'b0, 2'b00};

    funct3 = 3'b000; funct7b5 = 1'b0; flags = 4'b0000;

    for (int r = 0; r < 16; r++) begin
      do_reset();
      op = tbl[r].op; funct3 = tbl[r].f3; funct7b5 = tbl[r].f7; flags = tbl[r].fl;
      cycles = -1; left = 0; irw = 0; ill = 0;
      o_alu = 4'hF; o_pcw = 1'bx; o_rw = 1'bx; o_rs = 2'bxx;
      for (int idx = 0; idx < 40; idx++) begin
        mem_ready = (idx < 16) ? tbl[r].mr_mask[4'(idx)] : 1'b1;
        @(negedge clk);
        if (left && result_src == 2'b10) begin
          cycles = idx;
          break;
        end
        if (result_src != 2'b10) left = 1;
        irw += int'(ir_write);
        ill += int'(illegal_instr);
        if (idx == tbl[r].chk) begin
          o_alu = alu_control;
          o_pcw = pc_write;
        end
        o_rw = reg_write;
        o_rs = result_src;
        tick();
      end
      check($sformatf("vec%0d_cycles", r), cycles, tbl[r].cyc);
      check($sformatf("vec%0d_alu", r), o_alu, tbl[r].alu);
      check($sformatf("vec%0d_pc_write", r), o_pcw, tbl[r].pcw);
      check($sformatf("vec%0d_illegal", r), ill, tbl[r].ill);
      check($sformatf("vec%0d_ir_write_pulses", r), irw, 1);
      check($sformatf("vec%0d_last_reg_write", r), o_rw, tbl[r].rw);
      check($sformatf("vec%0d_last_result_src", r), o_rs, tbl[r].rs);
    end

    // sw interrupted by reset while the write strobe is up
    do_reset();
    op = T_SW; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_mem_write_before_reset", mem_write, 1);
    #1 reset = 1'b1;
    #1;
    check("sw_mem_write_at_reset", mem_write, 0);
    check("sw_reg_write_at_reset", reg_write, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_fetch_outputs",
          {ir_write, pc_write, reg_write, mem_write, adr_src, result_src, alu_src_a, alu_src_b},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10});
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check("post_reset_fetch_ir_write", ir_write, 1);
    tick();

    // randomized instruction stream against the trace model
    pool = '{T_LW, T_SW, T_R, T_I, T_B, T_JAL, T_JALR, T_LUI, T_AUIPC};
    do_reset();
    msk = 19'h7FF1F;
    for (int n = 0; n < 120; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      op = (sel == 9) ? 7'($urandom) : pool[sel];
      funct3 = 3'($urandom); funct7b5 = 1'($urandom); flags = 4'($urandom);
      build(op, funct3, funct7b5, flags, $urandom_range(0, 2), $urandom_range(0, 2));
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_ready = exp_q[i].mr;
        @(negedge clk);
        if (exp_q[i].ck_imm)
          check($sformatf("rnd%0d_op%b_step%0d", n, op, i), obs, exp_q[i].v);
        else
          check($sformatf("rnd%0d_op%b_step%0d", n, op, i), obs & msk, exp_q[i].v & msk);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
